// File: rtl/vga_address_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_address_decoder
//  Description : Registered raster-to-frame-buffer byte address translator for
//                2x upscaled 320x240x8bpp images on a 640x480 raster, with
//                frame-start buffer select latching. Optional one-pixel
//                lookahead enabled by VGA_ADDR_PREFETCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_address_decoder #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          H_TOTAL   = 800,
  parameter int          V_TOTAL   = 525,
  parameter int          IMG_W     = 320,
  parameter logic [31:0] IMG0_BASE = 32'h0001_0000,
  parameter logic [31:0] IMG1_BASE = 32'h0002_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        image_select,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  output logic [31:0] video_address,
  output logic        addr_valid
);

  logic        sel_q;
  logic        sel_eff;
  logic [10:0] col;
  logic [10:0] row;
  logic [10:0] x;
  logic [10:0] y;
  logic [16:0] offset;
  logic [31:0] base;
  logic        visible;
  logic [31:0] addr_d;
  logic [31:0] addr_q;
  logic        valid_d;
  logic        valid_q;

  // The buffer select is only sampled at frame start to avoid tearing.
  assign sel_eff = (hcnt == 10'd0 && vcnt == 10'd0) ? image_select : sel_q;

`ifdef VGA_ADDR_PREFETCH_EN
  always_comb begin
    col = {1'b0, hcnt} + 11'd1;
    row = {1'b0, vcnt};
    if (hcnt == 10'(H_TOTAL - 1)) begin
      col = 11'd0;
      row = (vcnt == 10'(V_TOTAL - 1)) ? 11'd0 : ({1'b0, vcnt} + 11'd1);
    end
  end
`else
  assign col = {1'b0, hcnt};
  assign row = {1'b0, vcnt};
`endif

  assign x = col >> 1;
  assign y = row >> 1;

  // Offset only matters for visible pixels, where it stays below 2^17.
  generate
    if (IMG_W == 320) begin : g_shift_add
      assign offset = ({6'd0, y} << 8) + ({6'd0, y} << 6) + {6'd0, x};
    end else begin : g_mult
      assign offset = ({6'd0, y} * 17'(IMG_W)) + {6'd0, x};
    end
  endgenerate

  assign base    = sel_eff ? IMG1_BASE : IMG0_BASE;
  assign visible = (col < 11'(H_ACTIVE)) && (row < 11'(V_ACTIVE));
  assign addr_d  = visible ? (base + {15'd0, offset}) : base;
  assign valid_d = visible;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= 1'b0;
      addr_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= sel_eff;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign video_address = addr_q;
  assign addr_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_address_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_address_decoder
//  Description : Self-checking bench for vga_address_decoder with an
//                arithmetic reference model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_address_decoder;

  logic        clk;
  logic        reset;
  logic        image_select;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [31:0] video_address;
  logic        addr_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  vga_address_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .image_select  (image_select),
    .hcnt          (hcnt),
    .vcnt          (vcnt),
    .video_address (video_address),
    .addr_valid    (addr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: address = base + (row/2)*320 + col/2 for visible pixels.
  function automatic logic [32:0] model(input int h, input int v, input logic s);
    int col;
    int row;
    logic [31:0] b;
    col = h;
    row = v;
`ifdef VGA_ADDR_PREFETCH_EN
    if (h == 799) begin
      col = 0;
      row = (v == 524) ? 0 : v + 1;
    end else begin
      col = h + 1;
    end
`endif
    b = s ? 32'h0002_4000 : 32'h0001_0000;
    if (col < 640 && row < 480)
      return {1'b1, b + 32'((row / 2) * 320 + col / 2)};
    return {1'b0, b};
  endfunction

  logic        m_sel;
  logic [31:0] e_addr;
  logic        e_valid;
  logic        s_eff;
  assign s_eff = (hcnt == 10'd0 && vcnt == 10'd0) ? image_select : m_sel;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sel   <= 1'b0;
      e_addr  <= 32'h0;
      e_valid <= 1'b0;
    end else begin
      m_sel             <= s_eff;
      {e_valid, e_addr} <= model(int'(hcnt), int'(vcnt), s_eff);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (video_address !== e_addr || addr_valid !== e_valid) begin
        n_bad++;
        $display("FAIL model h=%0d v=%0d: got addr=%h valid=%b, want addr=%h valid=%b",
                 hcnt, vcnt, video_address, addr_valid, e_addr, e_valid);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] ea, input logic ev);
    n_cmp++;
    if (video_address !== ea || addr_valid !== ev) begin
      n_bad++;
      $display("FAIL %s: got addr=%h valid=%b, want addr=%h valid=%b",
               name, video_address, addr_valid, ea, ev);
    end
  endtask

  task automatic step(input int h, input int v, input logic s);
    @(negedge clk);
    hcnt         = 10'(h);
    vcnt         = 10'(v);
    image_select = s;
    @(posedge clk);
    #1;
  endtask

  int rows[8] = '{0, 1, 2, 239, 478, 479, 480, 524};

  initial begin
    logic [31:0] prev;
    logic        prev_ok;
    reset        = 1'b0;
    image_select = 1'b0;
    hcnt         = 10'd5;
    vcnt         = 10'd5;
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hcnt = hcnt ^ 10'd1;
      vcnt = vcnt ^ 10'd2;
      @(posedge clk);
      #1;
      check_lit("reset_hold", 32'h0, 1'b0);
    end
    chk_en = 1'b1;

    step(0, 0, 0);
    check_lit("reset_hold_last", 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_lit("first_after_reset", 32'h0001_0000, 1'b1);

`ifndef VGA_ADDR_PREFETCH_EN
    step(639, 479, 0); check_lit("corner_last", 32'h0002_2BFF, 1'b1);
    step(640, 479, 0); check_lit("corner_h640", 32'h0001_0000, 1'b0);
    step(0, 0, 1);     check_lit("buf1_start", 32'h0002_4000, 1'b1);
    step(10, 3, 0);    check_lit("buf1_pix", 32'h0002_4145, 1'b1);
    step(0, 0, 0);     check_lit("tear_start0", 32'h0001_0000, 1'b1);
    step(5, 100, 1);   check_lit("tear_mid", 32'h0001_3E82, 1'b1);
    step(639, 479, 1); check_lit("tear_end", 32'h0002_2BFF, 1'b1);
    step(0, 0, 1);     check_lit("tear_switch", 32'h0002_4000, 1'b1);
    step(1023, 1023, 1); check_lit("out_of_range", 32'h0002_4000, 1'b0);
    // Async reset mid-cycle, then resume mid-frame on buffer 0.
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_lit("async_reset", 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(10, 3, 1);    check_lit("resume_sel0", 32'h0001_0145, 1'b1);
`else
    step(1, 0, 0);     check_lit("pf_h1", 32'h0001_0001, 1'b1);
    step(799, 0, 0);   check_lit("pf_h799", 32'h0001_0000, 1'b1);
    step(639, 0, 0);   check_lit("pf_h639", 32'h0001_0000, 1'b0);
    step(638, 479, 0); check_lit("pf_corner", 32'h0002_2BFF, 1'b1);
    step(799, 524, 0); check_lit("pf_wrap", 32'h0001_0000, 1'b1);
    step(0, 0, 1);     check_lit("pf_buf1", 32'h0002_4000, 1'b1);
    step(9, 3, 0);     check_lit("pf_buf1_pix", 32'h0002_4145, 1'b1);
`endif

    for (int r = 0; r < 8; r++) begin
      prev_ok = 1'b0;
      prev    = 32'h0;
      for (int h = 0; h < 800; h++) begin
        step(h, rows[r], 1'b0);
        if (addr_valid) begin
          if (prev_ok) begin
            n_cmp++;
            if (video_address < prev) begin
              n_bad++;
              $display("FAIL monotonic row=%0d h=%0d: got addr=%h, want >= %h",
                       rows[r], h, video_address, prev);
            end
          end
          prev    = video_address;
          prev_ok = 1'b1;
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
